// File: rtl/core_pkg.sv
// Shared core types for the LSU/dcache arbitration slice: access size,
// arbiter FSM states, request source tags and the packed dcache request.
package core_pkg;

  localparam int unsigned CORE_XLEN = 64;

  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_D} inst_size_t;

  typedef enum logic [1:0] {RUN, DRAIN, ACK} arb_state_e;

  typedef enum logic {SRC_LD, SRC_ST} arb_src_e;

  typedef struct packed {
    logic                 we;
    logic [CORE_XLEN-1:0] addr;
    inst_size_t           size;
    logic [CORE_XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/lsu_dcache_arbiter_if.sv
// Dcache-side request/response bus. The arbiter is the master, the dcache the slave.
interface lsu_dcache_arbiter_if
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 64
);

  // Request: a transfer happens on a cycle where valid && ready. Once valid is
  // raised it stays high with all fields stable until that cycle. Responses
  // come back in order and are never back-pressured.
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic            mem_req_we_o;
  logic [XLEN-1:0] mem_req_addr_o;
  inst_size_t      mem_req_size_o;
  logic [XLEN-1:0] mem_req_wdata_o;
  logic            mem_rsp_valid_i;
  logic [XLEN-1:0] mem_rsp_data_i;

  modport master (
    output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_size_o, mem_req_wdata_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
  );

  modport slave (
    input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_size_o, mem_req_wdata_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
  );

endinterface

// File: rtl/arb_starve_prio2.sv
// Two-way load/store arbiter: loads win by default, a saturating starvation
// counter forces a store through, and a lock holds a stalled grant until handshake.
module arb_starve_prio2
  import core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ld_elig,
  input  logic     st_elig,
  input  logic     ld_valid,
  input  logic     st_valid,
  input  logic     mem_ready,
  output logic     req_valid,
  output arb_src_e src,
  output logic     ld_ready,
  output logic     st_ready,
  output logic     lock
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt_q;
  logic          lock_q;
  arb_src_e      lock_src_q;

  // A locked grant follows the raw requester valid, so a load caught by a
  // fence still completes even though it is no longer eligible.
  always_comb begin
    src       = SRC_LD;
    req_valid = 1'b0;
    if (lock_q) begin
      src       = lock_src_q;
      req_valid = (lock_src_q == SRC_ST) ? st_valid : ld_valid;
    end else if (st_elig && (!ld_elig || starve_cnt_q >= SW'(STARVE_LIMIT))) begin
      src       = SRC_ST;
      req_valid = 1'b1;
    end else if (ld_elig) begin
      src       = SRC_LD;
      req_valid = 1'b1;
    end
  end

  assign ld_ready = req_valid && (src == SRC_LD) && mem_ready;
  assign st_ready = req_valid && (src == SRC_ST) && mem_ready;
  assign lock     = lock_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_src_q   <= SRC_LD;
      starve_cnt_q <= '0;
    end else begin
      if (req_valid && !mem_ready) begin
        lock_q     <= 1'b1;
        lock_src_q <= src;
      end else if (req_valid && mem_ready) begin
        lock_q <= 1'b0;
      end
      if (st_ready) begin
        starve_cnt_q <= '0;
      end else if (st_valid && starve_cnt_q != SW'(STARVE_LIMIT)) begin
        starve_cnt_q <= starve_cnt_q + SW'(1);
      end
    end
  end

endmodule

// File: rtl/lsu_dcache_arbiter.sv
// Shares the dcache request port between LSU loads and store-queue drain,
// counts in-flight loads and sequences the fence/drain handshake.
module lsu_dcache_arbiter
  import core_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_OUT_LD   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ld_req_valid_i,
  output logic                             ld_req_ready_o,
  input  logic [XLEN-1:0]                  ld_req_addr_i,
  input  inst_size_t                       ld_req_size_i,
  input  logic                             st_req_valid_i,
  output logic                             st_req_ready_o,
  input  logic [XLEN-1:0]                  st_req_addr_i,
  input  inst_size_t                       st_req_size_i,
  input  logic [XLEN-1:0]                  st_req_data_i,
  input  logic                             sq_empty_i,
  input  logic                             fence_req_i,
  output logic                             fence_ack_o,
  lsu_dcache_arbiter_if.master             mem,
  output logic                             ld_rsp_valid_o,
  output logic [XLEN-1:0]                  ld_rsp_data_o,
  output logic [$clog2(MAX_OUT_LD+1)-1:0]  out_ld_o,
  output logic                             err_o,
  output arb_state_e                       state_o
);

  localparam int unsigned OW = $clog2(MAX_OUT_LD + 1);

  arb_state_e    state_q, state_d;
  logic [OW-1:0] out_ld_q;
  logic          err_q;
  logic          ld_elig, st_elig, lock, req_valid, rsp_dec;
  arb_src_e      src;

  assign ld_elig = ld_req_valid_i && (state_q == RUN) && (out_ld_q < OW'(MAX_OUT_LD));
  assign st_elig = st_req_valid_i && (state_q != ACK);

  arb_starve_prio2 #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .ld_elig   (ld_elig),
    .st_elig   (st_elig),
    .ld_valid  (ld_req_valid_i),
    .st_valid  (st_req_valid_i),
    .mem_ready (mem.mem_req_ready_i),
    .req_valid (req_valid),
    .src       (src),
    .ld_ready  (ld_req_ready_o),
    .st_ready  (st_req_ready_o),
    .lock      (lock)
  );

  assign mem.mem_req_valid_o = req_valid;
  assign mem.mem_req_we_o    = (src == SRC_ST);
  assign mem.mem_req_addr_o  = (src == SRC_ST) ? st_req_addr_i : ld_req_addr_i;
  assign mem.mem_req_size_o  = (src == SRC_ST) ? st_req_size_i : ld_req_size_i;
  assign mem.mem_req_wdata_o = (src == SRC_ST) ? st_req_data_i : '0;

  assign ld_rsp_valid_o = mem.mem_rsp_valid_i;
  assign ld_rsp_data_o  = mem.mem_rsp_data_i;

  // Drain completes only once nothing is queued, in flight, or half-issued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (fence_req_i) state_d = DRAIN;
      DRAIN:   if (sq_empty_i && out_ld_q == '0 && !lock) state_d = ACK;
      ACK:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign fence_ack_o = (state_q == ACK);
  assign state_o     = state_q;

  // A response with nothing outstanding is flagged rather than underflowing.
  assign rsp_dec = mem.mem_rsp_valid_i && (out_ld_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      out_ld_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case ({ld_req_ready_o, rsp_dec})
        2'b10:   out_ld_q <= out_ld_q + OW'(1);
        2'b01:   out_ld_q <= out_ld_q - OW'(1);
        default: out_ld_q <= out_ld_q;
      endcase
      if (mem.mem_rsp_valid_i && out_ld_q == '0) err_q <= 1'b1;
    end
  end

  assign out_ld_o = out_ld_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// Bench for lsu_dcache_arbiter: per-scenario tasks plus a scoreboard that matches
// every dcache handshake and forwarded load response against expected queues.
module tb_lsu_dcache_arbiter;
  import core_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam int unsigned OW   = 3;
  localparam int unsigned W    = $bits(mem_req_t);

  logic            clk;
  logic            rst;
  logic            ld_req_valid_i, ld_req_ready_o;
  logic [XLEN-1:0] ld_req_addr_i;
  inst_size_t      ld_req_size_i;
  logic            st_req_valid_i, st_req_ready_o;
  logic [XLEN-1:0] st_req_addr_i, st_req_data_i;
  inst_size_t      st_req_size_i;
  logic            sq_empty_i, fence_req_i, fence_ack_o;
  logic            ld_rsp_valid_o;
  logic [XLEN-1:0] ld_rsp_data_o;
  logic [OW-1:0]   out_ld_o;
  logic            err_o;
  arb_state_e      state_o;

  lsu_dcache_arbiter_if #(.XLEN(XLEN)) mif ();

  lsu_dcache_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4), .MAX_OUT_LD(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ld_req_valid_i (ld_req_valid_i),
    .ld_req_ready_o (ld_req_ready_o),
    .ld_req_addr_i  (ld_req_addr_i),
    .ld_req_size_i  (ld_req_size_i),
    .st_req_valid_i (st_req_valid_i),
    .st_req_ready_o (st_req_ready_o),
    .st_req_addr_i  (st_req_addr_i),
    .st_req_size_i  (st_req_size_i),
    .st_req_data_i  (st_req_data_i),
    .sq_empty_i     (sq_empty_i),
    .fence_req_i    (fence_req_i),
    .fence_ack_o    (fence_ack_o),
    .mem            (mif),
    .ld_rsp_valid_o (ld_rsp_valid_o),
    .ld_rsp_data_o  (ld_rsp_data_o),
    .out_ld_o       (out_ld_o),
    .err_o          (err_o),
    .state_o        (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int pend         = 0;

  logic [W-1:0]    exp_q[$];
  logic [XLEN-1:0] rsp_q[$];

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (mif.mem_req_valid_o && mif.mem_req_ready_i) begin
        logic [W-1:0] obs, e;
        obs = {mif.mem_req_we_o, mif.mem_req_addr_o, mif.mem_req_size_o, mif.mem_req_wdata_o};
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL mem_req_unexpected got %h required none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            tests_failed++;
            $display("FAIL mem_req got %h required %h", obs, e);
          end
        end
      end
      if (ld_rsp_valid_o) begin
        logic [XLEN-1:0] er;
        tests_run++;
        if (rsp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL ld_rsp_unexpected got %h required none", ld_rsp_data_o);
        end else begin
          er = rsp_q.pop_front();
          if (ld_rsp_data_o !== er) begin
            tests_failed++;
            $display("FAIL ld_rsp got %h required %h", ld_rsp_data_o, er);
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic void push_req(logic we, logic [XLEN-1:0] a, inst_size_t s, logic [XLEN-1:0] d);
    exp_q.push_back({we, a, s, d});
  endfunction

  task automatic drive_rsp;
    logic [XLEN-1:0] d;
    d = {$urandom, $urandom};
    mif.mem_rsp_valid_i = 1'b1;
    mif.mem_rsp_data_i  = d;
    rsp_q.push_back(d);
  endtask

  task automatic drain_rsp;
    while (pend > 0) begin
      drive_rsp();
      pend--;
      step();
    end
    mif.mem_rsp_valid_i = 1'b0;
  endtask

  task automatic issue_load(logic [XLEN-1:0] a);
    ld_req_valid_i = 1'b1;
    ld_req_addr_i  = a;
    ld_req_size_i  = SIZE_D;
    push_req(1'b0, a, SIZE_D, '0);
    step();
    pend++;
    ld_req_valid_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    tests_run++;
    if (mif.mem_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_valid got %b required 0", mif.mem_req_valid_o); end
    tests_run++;
    if (fence_ack_o !== 1'b0) begin tests_failed++; $display("FAIL reset_fence_ack got %b required 0", fence_ack_o); end
    tests_run++;
    if (ld_rsp_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got %b required 0", ld_rsp_valid_o); end
    tests_run++;
    if (out_ld_o !== 3'd0) begin tests_failed++; $display("FAIL reset_out_ld got %0d required 0", out_ld_o); end
    tests_run++;
    if (err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b required 0", err_o); end
    tests_run++;
    if (state_o !== RUN) begin tests_failed++; $display("FAIL reset_state got %0d required %0d", state_o, RUN); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_load_only;
    mif.mem_req_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_req_valid_i = 1'b1;
      ld_req_addr_i  = 64'h1000 + 64'(8 * i);
      ld_req_size_i  = SIZE_D;
      push_req(1'b0, ld_req_addr_i, SIZE_D, '0);
      @(negedge clk);
      tests_run++;
      if (ld_req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ld_only_ready[%0d] got %b required 1", i, ld_req_ready_o); end
      step();
    end
    ld_req_valid_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_ld_o !== 3'd3) begin tests_failed++; $display("FAIL ld_only_out_ld got %0d required 3", out_ld_o); end
    step();
    pend = 3;
    drain_rsp();
    @(negedge clk);
    tests_run++;
    if (out_ld_o !== 3'd0) begin tests_failed++; $display("FAIL ld_only_out_ld_drained got %0d required 0", out_ld_o); end
    step();
  endtask

  task automatic test_starve;
    int nld = 0;
    int nst = 0;
    logic exp_st;
    mif.mem_req_ready_i = 1'b1;
    sq_empty_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_st         = (i % 5 == 4);
      ld_req_valid_i = 1'b1;
      ld_req_addr_i  = 64'h2000 + 64'(8 * nld);
      ld_req_size_i  = SIZE_W;
      st_req_valid_i = 1'b1;
      st_req_addr_i  = 64'h3000 + 64'(8 * nst);
      st_req_size_i  = SIZE_D;
      st_req_data_i  = {$urandom, $urandom};
      if (pend > 0) begin drive_rsp(); pend--; end
      else mif.mem_rsp_valid_i = 1'b0;
      if (exp_st) begin
        push_req(1'b1, st_req_addr_i, SIZE_D, st_req_data_i);
        nst++;
      end else begin
        push_req(1'b0, ld_req_addr_i, SIZE_W, '0);
        nld++;
        pend++;
      end
      @(negedge clk);
      tests_run++;
      if (st_req_ready_o !== exp_st || ld_req_ready_o !== !exp_st) begin
        tests_failed++;
        $display("FAIL starve_grant[%0d] got ld=%b st=%b required st=%b", i, ld_req_ready_o, st_req_ready_o, exp_st);
      end
      step();
    end
    ld_req_valid_i = 1'b0;
    st_req_valid_i = 1'b0;
    sq_empty_i     = 1'b1;
    drain_rsp();
  endtask

  task automatic test_stall;
    logic [XLEN-1:0] sd;
    sd = 64'hCAFE_F00D_1234_5678;
    mif.mem_req_ready_i = 1'b0;
    sq_empty_i     = 1'b0;
    st_req_valid_i = 1'b1;
    st_req_addr_i  = 64'h4000;
    st_req_size_i  = SIZE_W;
    st_req_data_i  = sd;
    @(negedge clk);
    tests_run++;
    if (mif.mem_req_valid_o !== 1'b1 || mif.mem_req_we_o !== 1'b1) begin
      tests_failed++; $display("FAIL stall_first got valid=%b we=%b required 1/1", mif.mem_req_valid_o, mif.mem_req_we_o);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      ld_req_valid_i = 1'b1;
      ld_req_addr_i  = 64'h5000;
      ld_req_size_i  = SIZE_D;
      @(negedge clk);
      tests_run++;
      if (mif.mem_req_we_o !== 1'b1 || mif.mem_req_addr_o !== 64'h4000 || mif.mem_req_wdata_o !== sd || ld_req_ready_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d] got we=%b addr=%h data=%h ldr=%b required 1 4000 %h 0",
                 i, mif.mem_req_we_o, mif.mem_req_addr_o, mif.mem_req_wdata_o, ld_req_ready_o, sd);
      end
      step();
    end
    mif.mem_req_ready_i = 1'b1;
    push_req(1'b1, 64'h4000, SIZE_W, sd);
    @(negedge clk);
    tests_run++;
    if (st_req_ready_o !== 1'b1 || ld_req_ready_o !== 1'b0) begin
      tests_failed++; $display("FAIL stall_release got st=%b ld=%b required 1/0", st_req_ready_o, ld_req_ready_o);
    end
    step();
    st_req_valid_i = 1'b0;
    sq_empty_i     = 1'b1;
    push_req(1'b0, 64'h5000, SIZE_D, '0);
    @(negedge clk);
    tests_run++;
    if (ld_req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL stall_load_after got %b required 1", ld_req_ready_o); end
    step();
    pend++;
    ld_req_valid_i = 1'b0;
    drain_rsp();
  endtask

  task automatic test_max_out;
    mif.mem_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) issue_load(64'h6000 + 64'(8 * i));
    ld_req_valid_i = 1'b1;
    ld_req_addr_i  = 64'h6020;
    @(negedge clk);
    tests_run++;
    if (out_ld_o !== 3'd4 || ld_req_ready_o !== 1'b0 || mif.mem_req_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL max_out_block got out=%0d ldr=%b mv=%b required 4/0/0", out_ld_o, ld_req_ready_o, mif.mem_req_valid_o);
    end
    step();
    drive_rsp(); pend--;
    @(negedge clk);
    tests_run++;
    if (ld_req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL max_out_rsp_only got %b required 0", ld_req_ready_o); end
    step();
    drive_rsp(); pend--;
    push_req(1'b0, 64'h6020, SIZE_D, '0); pend++;
    @(negedge clk);
    tests_run++;
    if (ld_req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL max_out_both_ready got %b required 1", ld_req_ready_o); end
    step();
    mif.mem_rsp_valid_i = 1'b0;
    ld_req_addr_i = 64'h6028;
    push_req(1'b0, 64'h6028, SIZE_D, '0); pend++;
    @(negedge clk);
    tests_run++;
    if (out_ld_o !== 3'd3) begin tests_failed++; $display("FAIL max_out_same_cycle got %0d required 3", out_ld_o); end
    step();
    ld_req_valid_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_ld_o !== 3'd4) begin tests_failed++; $display("FAIL max_out_refill got %0d required 4", out_ld_o); end
    step();
    drain_rsp();
  endtask

  task automatic test_fence;
    mif.mem_req_ready_i = 1'b1;
    issue_load(64'h7000);
    issue_load(64'h7008);
    sq_empty_i  = 1'b0;
    fence_req_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (fence_ack_o !== 1'b0) begin tests_failed++; $display("FAIL fence_early_ack got %b required 0", fence_ack_o); end
    step();
    ld_req_valid_i = 1'b1;
    ld_req_addr_i  = 64'h7010;
    st_req_valid_i = 1'b1;
    st_req_addr_i  = 64'h8000;
    st_req_size_i  = SIZE_H;
    st_req_data_i  = 64'h0000_0000_0000_BEEF;
    push_req(1'b1, 64'h8000, SIZE_H, 64'h0000_0000_0000_BEEF);
    @(negedge clk);
    tests_run++;
    if (state_o !== DRAIN || ld_req_ready_o !== 1'b0 || st_req_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL fence_drain got st=%0d ldr=%b str=%b required DRAIN/0/1", state_o, ld_req_ready_o, st_req_ready_o);
    end
    step();
    st_req_valid_i = 1'b0;
    sq_empty_i     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_rsp(); pend--;
      @(negedge clk);
      tests_run++;
      if (fence_ack_o !== 1'b0 || ld_req_ready_o !== 1'b0) begin
        tests_failed++; $display("FAIL fence_wait[%0d] got ack=%b ldr=%b required 0/0", i, fence_ack_o, ld_req_ready_o);
      end
      step();
    end
    mif.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (fence_ack_o !== 1'b0 || out_ld_o !== 3'd0) begin
      tests_failed++; $display("FAIL fence_pre_ack got ack=%b out=%0d required 0/0", fence_ack_o, out_ld_o);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (fence_ack_o !== 1'b1 || ld_req_ready_o !== 1'b0) begin
      tests_failed++; $display("FAIL fence_ack got ack=%b ldr=%b required 1/0", fence_ack_o, ld_req_ready_o);
    end
    fence_req_i = 1'b0;
    step();
    push_req(1'b0, 64'h7010, SIZE_D, '0);
    @(negedge clk);
    tests_run++;
    if (fence_ack_o !== 1'b0 || ld_req_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL fence_resume got ack=%b ldr=%b required 0/1", fence_ack_o, ld_req_ready_o);
    end
    step();
    pend++;
    ld_req_valid_i = 1'b0;
    drain_rsp();
  endtask

  task automatic test_err_and_reset;
    mif.mem_req_ready_i = 1'b1;
    drive_rsp();
    @(negedge clk);
    tests_run++;
    if (err_o !== 1'b0) begin tests_failed++; $display("FAIL err_before got %b required 0", err_o); end
    step();
    mif.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (err_o !== 1'b1 || out_ld_o !== 3'd0) begin
      tests_failed++; $display("FAIL err_set got err=%b out=%0d required 1/0", err_o, out_ld_o);
    end
    step();
    issue_load(64'hA000);
    step();
    @(negedge clk);
    tests_run++;
    if (err_o !== 1'b1) begin tests_failed++; $display("FAIL err_sticky got %b required 1", err_o); end
    mif.mem_req_ready_i = 1'b0;
    st_req_valid_i = 1'b1;
    st_req_addr_i  = 64'h9000;
    st_req_size_i  = SIZE_B;
    st_req_data_i  = 64'h5A;
    sq_empty_i     = 1'b0;
    step();
    @(negedge clk);
    tests_run++;
    if (mif.mem_req_valid_o !== 1'b1 || mif.mem_req_we_o !== 1'b1) begin
      tests_failed++; $display("FAIL lock_store got valid=%b we=%b required 1/1", mif.mem_req_valid_o, mif.mem_req_we_o);
    end
    step();
    rst            = 1'b1;
    st_req_valid_i = 1'b0;
    sq_empty_i     = 1'b1;
    step();
    rst  = 1'b0;
    pend = 0;
    @(negedge clk);
    tests_run++;
    if (mif.mem_req_valid_o !== 1'b0 || out_ld_o !== 3'd0 || err_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_lock got valid=%b out=%0d err=%b required 0/0/0", mif.mem_req_valid_o, out_ld_o, err_o);
    end
    step();
    mif.mem_req_ready_i = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst                 = 1'b1;
    ld_req_valid_i      = 1'b0;
    ld_req_addr_i       = '0;
    ld_req_size_i       = SIZE_B;
    st_req_valid_i      = 1'b0;
    st_req_addr_i       = '0;
    st_req_size_i       = SIZE_B;
    st_req_data_i       = '0;
    sq_empty_i          = 1'b1;
    fence_req_i         = 1'b0;
    mif.mem_req_ready_i = 1'b0;
    mif.mem_rsp_valid_i = 1'b0;
    mif.mem_rsp_data_i  = '0;

    test_reset();
    test_load_only();
    test_starve();
    test_stall();
    test_max_out();
    test_fence();
    test_err_and_reset();

    step();
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL leftover_req got %0d required 0", exp_q.size()); end
    tests_run++;
    if (rsp_q.size() != 0) begin tests_failed++; $display("FAIL leftover_rsp got %0d required 0", rsp_q.size()); end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
